// File: rtl/adder32.sv
// rtl/adder32.sv - registered 32-bit two-level carry-lookahead adder with carry-out and signed overflow
// Optional input register stage when ADDER32_INREG_EN is defined (latency 2 instead of 1).
module adder32 (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout,
    output logic        OVF
);

    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_cin;

`ifdef ADDER32_INREG_EN
    logic [31:0] a_d, a_q;
    logic [31:0] b_d, b_q;
    logic        cin_d, cin_q;

    always_comb begin
        a_d   = A;
        b_d   = B;
        cin_d = Cin;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cin_q <= cin_d;
        end
    end

    assign core_a   = a_q;
    assign core_b   = b_q;
    assign core_cin = cin_q;
`else
    assign core_a   = A;
    assign core_b   = B;
    assign core_cin = Cin;
`endif

    logic [31:0] bit_g;
    logic [31:0] bit_p;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;
    logic [32:0] carry;
    logic        run_p;
    logic        run_c;

    logic [31:0] s_d, s_q;
    logic        cout_d, cout_q;
    logic        ovf_d, ovf_q;

    always_comb begin
        bit_g = core_a & core_b;
        bit_p = core_a ^ core_b;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        carry = '0;
        run_p = 1'b0;
        run_c = 1'b0;

        for (int k = 0; k < 8; k++) begin
            grp_p[k] = &bit_p[4*k +: 4];
            grp_g[k] = bit_g[4*k+3]
                     | (bit_p[4*k+3] & bit_g[4*k+2])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_g[4*k+1])
                     | (bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k]);
        end

        // Second level: each group carry is the flattened sum-of-products, not a ripple chain.
        grp_c[0] = core_cin;
        for (int k = 0; k < 8; k++) begin
            run_p = 1'b1;
            run_c = 1'b0;
            for (int j = k; j >= 0; j--) begin
                run_c = run_c | (run_p & grp_g[j]);
                run_p = run_p & grp_p[j];
            end
            grp_c[k+1] = run_c | (run_p & core_cin);
        end

        // First level: bit carries inside each group from that group's carry-in.
        for (int k = 0; k < 8; k++) begin
            carry[4*k] = grp_c[k];
            for (int i = 1; i < 4; i++) begin
                run_p = 1'b1;
                run_c = 1'b0;
                for (int j = i - 1; j >= 0; j--) begin
                    run_c = run_c | (run_p & bit_g[4*k+j]);
                    run_p = run_p & bit_p[4*k+j];
                end
                carry[4*k+i] = run_c | (run_p & grp_c[k]);
            end
        end
        carry[32] = grp_c[8];

        s_d    = bit_p ^ carry[31:0];
        cout_d = carry[32];
        ovf_d  = carry[32] ^ carry[31];
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_adder32.sv
// tb/tb_adder32.sv - directed and reference-checked bench for adder32 (either ADDER32_INREG_EN build)
module tb_adder32;

`ifdef ADDER32_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Cin = 1'b0;
    logic [31:0] S;
    logic        Cout;
    logic        OVF;

    int n_vec = 0;
    int n_bad = 0;

    adder32 dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .A       (A),
        .B       (B),
        .Cin     (Cin),
        .S       (S),
        .Cout    (Cout),
        .OVF     (OVF)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic test_reset();
        A = 32'hFFFF_FFFF; B = 32'h0000_0001; Cin = 1'b1;
        #1 RESET_N = 1'b0;
        #1;
        n_vec++;
        if ({S, Cout, OVF} !== 34'h0) begin
            n_bad++;
            $display("FAIL reset_async: got S=%h Cout=%b OVF=%b want S=00000000 Cout=0 OVF=0", S, Cout, OVF);
        end
        repeat (2) @(posedge CLOCK);
        #1;
        n_vec++;
        if ({S, Cout, OVF} !== 34'h0) begin
            n_bad++;
            $display("FAIL reset_held: got S=%h Cout=%b OVF=%b want 0/0/0", S, Cout, OVF);
        end
        @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678};
        logic [31:0] vb [6] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'h1111_1111};
        logic        vc [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] es [6] = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h2345_6789};
        logic        eco[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        eov[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK);
            A = va[i]; B = vb[i]; Cin = vc[i];
            repeat (LAT) @(posedge CLOCK);
            #1;
            n_vec++;
            if ({S, Cout, OVF} !== {es[i], eco[i], eov[i]}) begin
                n_bad++;
                $display("FAIL directed[%0d]: got S=%h Cout=%b OVF=%b want S=%h Cout=%b OVF=%b",
                         i, S, Cout, OVF, es[i], eco[i], eov[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [3] = '{32'd1, 32'd3, 32'd5};
        logic [31:0] vb [3] = '{32'd2, 32'd4, 32'd6};
        logic [31:0] es [3] = '{32'd3, 32'd7, 32'd11};
        for (int i = 0; i < 3 + LAT; i++) begin
            @(negedge CLOCK);
            if (i >= LAT) begin
                n_vec++;
                if ({S, Cout, OVF} !== {es[i-LAT], 1'b0, 1'b0}) begin
                    n_bad++;
                    $display("FAIL back_to_back[%0d]: got S=%h Cout=%b OVF=%b want S=%h Cout=0 OVF=0",
                             i - LAT, S, Cout, OVF, es[i-LAT]);
                end
            end
            if (i < 3) begin
                A = va[i]; B = vb[i]; Cin = 1'b0;
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge CLOCK);
        A = 32'h0000_00FF; B = 32'h0000_0001; Cin = 1'b1;
        @(posedge CLOCK);
        #2 RESET_N = 1'b0;
        #1;
        n_vec++;
        if ({S, Cout, OVF} !== 34'h0) begin
            n_bad++;
            $display("FAIL mid_reset_assert: got S=%h Cout=%b OVF=%b want 0/0/0", S, Cout, OVF);
        end
        @(negedge CLOCK);
        RESET_N = 1'b1;
        #1;
        n_vec++;
        if ({S, Cout, OVF} !== 34'h0) begin
            n_bad++;
            $display("FAIL mid_reset_release: got S=%h Cout=%b OVF=%b want 0/0/0", S, Cout, OVF);
        end
        repeat (LAT) @(posedge CLOCK);
        #1;
        n_vec++;
        if ({S, Cout, OVF} !== {32'h0000_0101, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset_resume: got S=%h Cout=%b OVF=%b want S=00000101 Cout=0 OVF=0", S, Cout, OVF);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb, es;
        logic        rc, eco, eov;
        logic [32:0] full;
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1));
            full = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            es  = full[31:0];
            eco = full[32];
            eov = (ra[31] == rb[31]) && (es[31] != ra[31]);
            @(negedge CLOCK);
            A = ra; B = rb; Cin = rc;
            repeat (LAT) @(posedge CLOCK);
            #1;
            n_vec++;
            if ({S, Cout, OVF} !== {es, eco, eov}) begin
                n_bad++;
                $display("FAIL random[%0d] A=%h B=%h Cin=%b: got S=%h Cout=%b OVF=%b want S=%h Cout=%b OVF=%b",
                         i, ra, rb, rc, S, Cout, OVF, es, eco, eov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
